// File: rtl/weight_store.sv
// Double-buffered weight and tanh table store for the two-layer classifier.
// A streamed load fills the shadow bank; commit flips which bank drives the outputs.
module weight_store #(
    parameter int N1    = 98,
    parameter int N2    = 10,
    parameter int W_K   = 4,
    parameter int W_OUT = 16
) (
    input  logic                                  clk,
    input  logic                                  rstn,
    input  logic                                  load_start,
    input  logic                                  in_valid,
    input  logic [W_OUT-1:0]                      in_data,
    output logic                                  in_ready,
    output logic                                  load_busy,
    output logic                                  load_done,
    output logic                                  cfg_valid,
    output logic [N2-1:0][N1/2:0][W_K-1:0]        weights_n1_mag,
    output logic [N2-1:0][N1/2:0][W_K-1:0]        weights_n1_pol,
    output logic [N2:0][W_K-1:0]                  weights_n2,
    output logic [2**W_K-1:0][W_OUT-1:0]          tanh
);

    localparam int M     = N1 / 2 + 1;
    localparam int T     = 2 ** W_K;
    localparam int TOTAL = 2 * N2 * M + N2 + 1 + T;
    localparam int KW    = $clog2(TOTAL + 1);
    localparam int NW    = (N2 > 1) ? $clog2(N2) : 1;
    localparam int JW    = (M > 1) ? $clog2(M) : 1;
    localparam int IW    = $clog2(N2 + 1);

    localparam logic [KW-1:0] END_MAG = KW'(N2 * M - 1);
    localparam logic [KW-1:0] END_POL = KW'(2 * N2 * M - 1);
    localparam logic [KW-1:0] BASE_N2 = KW'(2 * N2 * M);
    localparam logic [KW-1:0] END_N2  = KW'(2 * N2 * M + N2);
    localparam logic [KW-1:0] BASE_T  = KW'(2 * N2 * M + N2 + 1);
    localparam logic [KW-1:0] END_T   = KW'(TOTAL - 1);

    typedef enum logic [2:0] {
        IDLE, LOAD_MAG, LOAD_POL, LOAD_N2, LOAD_TANH, COMMIT
    } state_t;

    state_t              state_q, state_d;
    logic [KW-1:0]       k_q, k_d;
    logic [NW-1:0]       n_q, n_d;
    logic [JW-1:0]       j_q, j_d;
    logic                sel_q;
    logic                done_q;
    logic                cfg_q;

    logic [1:0][N2-1:0][M-1:0][W_K-1:0] mag_q;
    logic [1:0][N2-1:0][M-1:0][W_K-1:0] pol_q;
    logic [1:0][N2:0][W_K-1:0]          n2_q;
    logic [1:0][T-1:0][W_OUT-1:0]       tanh_q;

    logic                accept;
    logic                wr_en;
    logic                wb;
    logic [IW-1:0]       n2_idx;
    logic [W_K-1:0]      t_idx;

    assign accept = in_valid & in_ready;
    assign wr_en  = accept & ~load_start;
    assign wb     = ~sel_q;
    assign n2_idx = IW'(k_q - BASE_N2);
    assign t_idx  = W_K'(k_q - BASE_T);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            k_q     <= '0;
            n_q     <= '0;
            j_q     <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            n_q     <= n_d;
            j_q     <= j_d;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        n_d     = n_q;
        j_d     = j_q;
        unique case (state_q)
            IDLE: begin
                if (load_start) begin
                    state_d = LOAD_MAG;
                    k_d     = '0;
                    n_d     = '0;
                    j_d     = '0;
                end
            end
            LOAD_MAG, LOAD_POL, LOAD_N2, LOAD_TANH: begin
                if (load_start) begin
                    state_d = LOAD_MAG;
                    k_d     = '0;
                    n_d     = '0;
                    j_d     = '0;
                end else if (accept) begin
                    k_d = k_q + KW'(1);
                    // (n, j) walks neuron/entry order for both mag and pol
                    if (j_q == JW'(M - 1)) begin
                        j_d = '0;
                        n_d = (n_q == NW'(N2 - 1)) ? '0 : n_q + NW'(1);
                    end else begin
                        j_d = j_q + JW'(1);
                    end
                    case (state_q)
                        LOAD_MAG:  if (k_q == END_MAG) state_d = LOAD_POL;
                        LOAD_POL:  if (k_q == END_POL) state_d = LOAD_N2;
                        LOAD_N2:   if (k_q == END_N2)  state_d = LOAD_TANH;
                        LOAD_TANH: if (k_q == END_T)   state_d = COMMIT;
                        default: ;
                    endcase
                end
            end
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        load_busy = 1'b0;
        unique case (state_q)
            LOAD_MAG, LOAD_POL, LOAD_N2, LOAD_TANH: begin
                in_ready  = 1'b1;
                load_busy = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mag_q  <= '0;
            pol_q  <= '0;
            n2_q   <= '0;
            tanh_q <= '0;
            sel_q  <= 1'b0;
            done_q <= 1'b0;
            cfg_q  <= 1'b0;
        end else begin
            done_q <= (state_q == COMMIT);
            if (state_q == COMMIT) begin
                sel_q <= ~sel_q;
                cfg_q <= 1'b1;
            end
            if (wr_en) begin
                case (state_q)
                    LOAD_MAG:  mag_q[wb][n_q][j_q] <= in_data[W_K-1:0];
                    LOAD_POL:  pol_q[wb][n_q][j_q] <= in_data[W_K-1:0];
                    LOAD_N2:   n2_q[wb][n2_idx]    <= in_data[W_K-1:0];
                    LOAD_TANH: tanh_q[wb][t_idx]   <= in_data;
                    default: ;
                endcase
            end
        end
    end

    assign load_done      = done_q;
    assign cfg_valid      = cfg_q;
    assign weights_n1_mag = mag_q[sel_q];
    assign weights_n1_pol = pol_q[sel_q];
    assign weights_n2     = n2_q[sel_q];
    assign tanh           = tanh_q[sel_q];

endmodule

// File: tb/tb_weight_store.sv
// Directed load sequences with random data and handshake gaps, checked
// against an index-mapping reference model of the active/shadow tables.
module tb_weight_store;

    localparam int N1    = 98;
    localparam int N2    = 10;
    localparam int W_K   = 4;
    localparam int W_OUT = 16;
    localparam int M     = N1 / 2 + 1;
    localparam int T     = 2 ** W_K;
    localparam int TOTAL = 2 * N2 * M + N2 + 1 + T;

    typedef logic [N2-1:0][M-1:0][W_K-1:0] n1_t;
    typedef logic [N2:0][W_K-1:0]          n2_t;
    typedef logic [T-1:0][W_OUT-1:0]       th_t;

    logic             clk;
    logic             rstn;
    logic             load_start;
    logic             in_valid;
    logic [W_OUT-1:0] in_data;
    logic             in_ready;
    logic             load_busy;
    logic             load_done;
    logic             cfg_valid;
    n1_t              weights_n1_mag;
    n1_t              weights_n1_pol;
    n2_t              weights_n2;
    th_t              tanh;

    n1_t a_mag, a_pol, s_mag, s_pol, t_mag, t_pol;
    n2_t a_n2, s_n2, t_n2;
    th_t a_th, s_th, t_th;

    logic [W_OUT-1:0] wdata [TOTAL];
    int n_cmp  = 0;
    int n_err  = 0;
    int n_done = 0;
    int d0;

    weight_store #(
        .N1(N1), .N2(N2), .W_K(W_K), .W_OUT(W_OUT)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .load_start     (load_start),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .in_ready       (in_ready),
        .load_busy      (load_busy),
        .load_done      (load_done),
        .cfg_valid      (cfg_valid),
        .weights_n1_mag (weights_n1_mag),
        .weights_n1_pol (weights_n1_pol),
        .weights_n2     (weights_n2),
        .tanh           (tanh)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (load_done === 1'b1) n_done++;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [W_OUT-1:0] obs,
                       input logic [W_OUT-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_tables(input string tag);
        int bad;
        n_cmp++;
        assert (weights_n1_mag === a_mag) else begin
            n_err++;
            bad = 0;
            for (int i = N2 * M - 1; i >= 0; i--)
                if (weights_n1_mag[i/M][i%M] !== a_mag[i/M][i%M]) bad = i;
            $error("FAIL %s.mag[%0d][%0d]: observed %0h expected %0h", tag,
                   bad / M, bad % M, weights_n1_mag[bad/M][bad%M], a_mag[bad/M][bad%M]);
        end
        n_cmp++;
        assert (weights_n1_pol === a_pol) else begin
            n_err++;
            bad = 0;
            for (int i = N2 * M - 1; i >= 0; i--)
                if (weights_n1_pol[i/M][i%M] !== a_pol[i/M][i%M]) bad = i;
            $error("FAIL %s.pol[%0d][%0d]: observed %0h expected %0h", tag,
                   bad / M, bad % M, weights_n1_pol[bad/M][bad%M], a_pol[bad/M][bad%M]);
        end
        n_cmp++;
        assert (weights_n2 === a_n2) else begin
            n_err++;
            bad = 0;
            for (int i = N2; i >= 0; i--)
                if (weights_n2[i] !== a_n2[i]) bad = i;
            $error("FAIL %s.n2[%0d]: observed %0h expected %0h", tag,
                   bad, weights_n2[bad], a_n2[bad]);
        end
        n_cmp++;
        assert (tanh === a_th) else begin
            n_err++;
            bad = 0;
            for (int i = T - 1; i >= 0; i--)
                if (tanh[i] !== a_th[i]) bad = i;
            $error("FAIL %s.tanh[%0d]: observed %0h expected %0h", tag,
                   bad, tanh[bad], a_th[bad]);
        end
    endtask

    // Reference: word k lands in a table entry by plain index arithmetic
    task automatic model_word(input int k, input logic [W_OUT-1:0] v);
        int r;
        if (k < N2 * M) begin
            s_mag[k/M][k%M] = v[W_K-1:0];
        end else if (k < 2 * N2 * M) begin
            r = k - N2 * M;
            s_pol[r/M][r%M] = v[W_K-1:0];
        end else if (k < 2 * N2 * M + N2 + 1) begin
            s_n2[k - 2 * N2 * M] = v[W_K-1:0];
        end else begin
            s_th[k - (2 * N2 * M + N2 + 1)] = v;
        end
    endtask

    task automatic model_commit;
        t_mag = a_mag; t_pol = a_pol; t_n2 = a_n2; t_th = a_th;
        a_mag = s_mag; a_pol = s_pol; a_n2 = s_n2; a_th = s_th;
        s_mag = t_mag; s_pol = t_pol; s_n2 = t_n2; s_th = t_th;
    endtask

    task automatic model_reset;
        a_mag = '0; a_pol = '0; a_n2 = '0; a_th = '0;
        s_mag = '0; s_pol = '0; s_n2 = '0; s_th = '0;
    endtask

    task automatic fill(input int pat);
        for (int k = 0; k < TOTAL; k++) begin
            if (pat == 0)      wdata[k] = W_OUT'(k);
            else if (pat == 1) wdata[k] = W_OUT'(k) ^ 16'hFFFF;
            else               wdata[k] = W_OUT'($urandom);
        end
    endtask

    task automatic start_load(input string tag);
        in_valid   = 1'b0;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        chk({tag, "_busy"}, 16'(load_busy), 16'd1);
        chk({tag, "_ready"}, 16'(in_ready), 16'd1);
    endtask

    task automatic send(input int from, input int to, input bit gaps);
        for (int k = from; k < to; k++) begin
            while (gaps && $urandom_range(1, 0) == 1) begin
                in_valid = 1'b0;
                in_data  = W_OUT'($urandom);
                tick();
            end
            in_valid = 1'b1;
            in_data  = wdata[k];
            model_word(k, wdata[k]);
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic do_commit(input string tag, input bit ls);
        chk({tag, "_pre_done"}, 16'(load_done), 16'd0);
        chk({tag, "_pre_ready"}, 16'(in_ready), 16'd0);
        chk_tables({tag, "_pre"});
        load_start = ls;
        tick();
        load_start = 1'b0;
        model_commit();
        chk({tag, "_done"}, 16'(load_done), 16'd1);
        chk({tag, "_cfg"}, 16'(cfg_valid), 16'd1);
        chk_tables({tag, "_post"});
        tick();
        chk({tag, "_done_off"}, 16'(load_done), 16'd0);
        chk({tag, "_idle_ready"}, 16'(in_ready), 16'd0);
    endtask

    task automatic spot_a(input string tag);
        chk({tag, "_mag1_2"}, 16'(weights_n1_mag[1][2]), 16'((50 * 1 + 2) % 16));
        chk({tag, "_pol3_7"}, 16'(weights_n1_pol[3][7]), 16'((500 + 150 + 7) % 16));
        chk({tag, "_n2_5"}, 16'(weights_n2[5]), 16'((1000 + 5) % 16));
        chk({tag, "_tanh15"}, tanh[15], 16'(1011 + 15));
    endtask

    initial begin
        rstn       = 1'b0;
        load_start = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        model_reset();
        repeat (3) tick();
        chk_tables("in_reset");
        rstn = 1'b1;
        tick();
        chk("rst_ready", 16'(in_ready), 16'd0);
        chk("rst_busy", 16'(load_busy), 16'd0);
        chk("rst_cfg", 16'(cfg_valid), 16'd0);
        chk("rst_done", 16'(load_done), 16'd0);
        chk_tables("rst");

        // words offered while idle must be dropped
        in_valid = 1'b1;
        repeat (4) begin
            in_data = W_OUT'($urandom);
            tick();
        end
        in_valid = 1'b0;
        chk("idle_ready", 16'(in_ready), 16'd0);
        chk("idle_no_done", 16'(n_done), 16'd0);
        chk_tables("idle_junk");

        fill(0);
        start_load("A");
        send(0, TOTAL, 1'b0);
        do_commit("A", 1'b0);
        spot_a("A");

        fill(1);
        start_load("B");
        send(0, 500, 1'b1);
        chk_tables("B_mid");
        send(500, TOTAL, 1'b1);
        do_commit("B", 1'b1);
        chk("B_tanh0", tanh[0], 16'hFC0C);
        tick();
        chk("B_ls_ignored", 16'(load_busy), 16'd0);

        fill(2);
        start_load("R");
        send(0, TOTAL, 1'b1);
        do_commit("R", 1'b0);

        d0 = n_done;
        fill(2);
        start_load("ab");
        send(0, 300, 1'b1);
        chk_tables("ab_mid");
        fill(0);
        start_load("ab2");
        chk_tables("ab_restart");
        send(0, TOTAL, 1'b0);
        do_commit("ab", 1'b0);
        spot_a("ab");
        chk("ab_one_done", 16'(n_done - d0), 16'd1);

        fill(0);
        start_load("rs");
        send(0, 700, 1'b1);
        d0 = n_done;
        rstn = 1'b0;
        #1;
        model_reset();
        chk_tables("rs_async");
        chk("rs_cfg", 16'(cfg_valid), 16'd0);
        chk("rs_ready", 16'(in_ready), 16'd0);
        chk("rs_busy", 16'(load_busy), 16'd0);
        tick();
        rstn = 1'b1;
        repeat (5) tick();
        chk("rs_no_done", 16'(n_done - d0), 16'd0);
        chk("rs_cfg_after", 16'(cfg_valid), 16'd0);
        chk("rs_ready_after", 16'(in_ready), 16'd0);
        chk_tables("rs_after");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/weight_store.md
WEIGHT_STORE -- requirements
Module: weight_store

Interface
REQ-001 SHALL have parameter N1, default 98: layer-1 input count; per-neuron table depth is N1/2+1.
REQ-002 SHALL have parameter N2, default 10: hidden neuron count.
REQ-003 SHALL have parameter W_K, default 4: weight width; tanh table depth is 2**W_K.
REQ-004 SHALL have parameter W_OUT, default 16: tanh entry width and load word width.
REQ-005 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rstn, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port load_start, input, 1: single-cycle request to begin a table load.
REQ-008 SHALL have port in_valid, input, 1: in_data is valid.
REQ-009 SHALL have port in_data, input, W_OUT: load word.
REQ-010 SHALL have port in_ready, output, 1: block accepts a word this cycle.
REQ-011 SHALL have port load_busy, output, 1: a load is in progress.
REQ-012 SHALL have port load_done, output, 1: one-cycle pulse when a new table set becomes active.
REQ-013 SHALL have port cfg_valid, output, 1: at least one complete load has been committed.
REQ-014 SHALL have ports weights_n1_mag and weights_n1_pol, output, [N2-1:0][N1/2:0][W_K-1:0]: active layer-1 weights.
REQ-015 SHALL have port weights_n2, output, [N2:0][W_K-1:0]: active layer-2 weights.
REQ-016 SHALL have port tanh, output, [2**W_K-1:0][W_OUT-1:0]: active activation table.

Function
REQ-017 SHALL hold two register banks, active and shadow; all outputs SHALL be driven from the active bank only.
REQ-018 SHALL implement FSM states IDLE, LOAD_MAG, LOAD_POL, LOAD_N2, LOAD_TANH, COMMIT.
REQ-019 SHALL move IDLE->LOAD_MAG on load_start, with the word index cleared to 0.
REQ-020 SHALL drive in_ready=load_busy=1 in the four LOAD_* states and 0 in IDLE and COMMIT.
REQ-021 SHALL accept a word only on a cycle with in_valid&in_ready, then increment the word index.
REQ-022 SHALL map word k as follows, with M=N1/2+1: k in [0,N2*M) -> mag[k/M][k%M]; next N2*M words -> pol, same ordering; next N2+1 -> weights_n2[i]; next 2**W_K -> tanh[t].
REQ-023 SHALL store bits in_data[W_K-1:0] for weight entries, ignoring the upper bits, and store the full in_data for tanh entries.
REQ-024 SHALL advance from each LOAD_* state on acceptance of its last word; acceptance of the final tanh word SHALL enter COMMIT.
REQ-025 SHALL, in COMMIT, on the next edge: swap the active and shadow banks, set cfg_valid=1, assert load_done for exactly the following cycle (coincident with new outputs), and return to IDLE.
REQ-026 SHALL, on load_start in any LOAD_* state, restart at word index 0 in LOAD_MAG; active outputs unchanged; partial shadow contents are don't-care.
REQ-027 SHALL ignore load_start in COMMIT; the commit completes normally.
REQ-028 SHALL drop in_valid with in_ready=0 without any state change.
REQ-029 SHALL keep the word index wide enough for 2*N2*M+N2+1+2**W_K-1, with no wrap-around.

Reset
REQ-030 SHALL, on rstn low (async), set both banks to 0, state=IDLE, word index=0, in_ready=load_busy=load_done=cfg_valid=0, and all table outputs 0.
REQ-031 SHALL, when reset is asserted mid-load or in COMMIT, discard the load entirely, with no swap and no load_done.

Verification (defaults: M=50, 1027 words per load)
REQ-032 SHALL cover: reset release -> all outputs 0, in_ready=0, cfg_valid=0, no load_done.
REQ-033 SHALL cover: load_start, then words k=0..1026 back-to-back with in_data=k -> load_done 2 cycles after the last accept edge; mag[n][j]=(50n+j)%16; pol[n][j]=(500+50n+j)%16; weights_n2[i]=(1000+i)%16; tanh[t]=1011+t; cfg_valid=1.
REQ-034 SHALL cover: the same load with random in_valid gaps (~50%) -> identical final tables; index advances only on accepted words.
REQ-035 SHALL cover: after a committed load A, load B (in_data=k^16'hFFFF) -> outputs equal A until the load_done cycle, then tanh[0]=16'hFC0C.
REQ-036 SHALL cover: load_start after 300 accepted words, then a full 1027-word load with in_data=k -> result as REQ-033; outputs unchanged during the aborted load; exactly one load_done.
REQ-037 SHALL cover: rstn low after 700 accepted words -> all outputs 0 immediately, cfg_valid=0, in_ready=0; no load_done afterwards.
